// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop, then device acknowledge. Lines are driven through open-drain pull-low enables.
module ps2_tx #(
  parameter int RTS_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_ACK
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     filter_q, filter_d;
  logic           fclk_q, fclk_d;
  logic [CW-1:0]  c_q, c_d;
  logic [3:0]     n_q, n_d;
  logic [8:0]     b_q, b_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic           fall_edge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      filter_q <= '0;
      fclk_q   <= 1'b0;
      c_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
      c_q      <= c_d;
      n_q      <= n_d;
      b_q      <= b_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // Debounce ps2c: the filtered clock only changes after 8 identical samples.
  always_comb begin
    filter_d = {ps2c, filter_q[7:1]};
    if (filter_q == 8'hFF)      fclk_d = 1'b1;
    else if (filter_q == 8'h00) fclk_d = 1'b0;
    else                        fclk_d = fclk_q;
    fall_edge = fclk_q & ~fclk_d;
  end

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    n_d          = n_q;
    b_d          = b_q;
    ack_d        = ack_q;
    err_d        = err_q;
    ps2c_oe      = 1'b0;
    ps2d_oe      = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ps2) begin
          b_d     = {~^din, din};
          c_d     = CW'(RTS_CYCLES - 1);
          state_d = S_RTS;
        end
      end
      // Falling edges here are our own clock hold, so they are not looked at.
      S_RTS: begin
        ps2c_oe = 1'b1;
        if (c_q == '0) state_d = S_START;
        else           c_d = c_q - 1'b1;
      end
      S_START: begin
        ps2d_oe = 1'b1;
        if (fall_edge) begin
          n_d     = 4'd8;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        ps2d_oe = ~b_q[0];
        if (fall_edge) begin
          b_d = {1'b0, b_q[8:1]};
          if (n_q == 4'd0) state_d = S_STOP;
          else             n_d = n_q - 4'd1;
        end
      end
      S_STOP: begin
        if (fall_edge) begin
          ack_d   = ~ps2d;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fclk_q && ps2d) begin
          tx_done_tick = 1'b1;
          err_d        = ~ack_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_idle = (state_q == S_IDLE);
  assign tx_err  = err_q;

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side paired with the PS/2 receiver and is used to issue mouse commands such as 0xF4 (enable reporting) and 0xFF (reset).
- It runs the request-to-send sequence, shifts out 8 data bits (LSB first), odd parity and stop, samples the device acknowledge, and reports completion and errors.
- It drives the bus through open-drain pull-low enables.
- tx_idle gates the receiver's rx_en so the receiver ignores host-driven traffic.

Parameters:
- RTS_CYCLES, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz). Minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- wr_ps2  in  1  one-cycle start strobe. Honoured only when tx_idle=1.
- din  in  8  byte to send. Sampled on the wr_ps2 cycle.
- ps2c  in  1  PS/2 clock line, raw value seen at the pad.
- ps2d  in  1  PS/2 data line, raw value seen at the pad.
- ps2c_oe  out  1  1 = pull the clock line low; 0 = release it.
- ps2d_oe  out  1  1 = pull the data line low; 0 = release it.
- tx_idle  out  1  1 when the FSM is in idle.
- tx_done_tick  out  1  one-cycle pulse at the end of a frame.
- tx_err  out  1  registered flag. 1 = the last frame received no acknowledge.

Behaviour:
- Reset: sampled on posedge clk while rst=0. It applies at any time, including mid-frame.
  - State returns to idle; both oe outputs are 0 (lines released).
  - tx_done_tick=0, tx_err=0, tx_idle=1.
  - Filter register = 0, filtered clock = 0, shift register = 0, counters = 0.
- Clock filter:
  - 8-bit shift register on ps2c.
  - The filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - fall_edge = filtered clock is 1 now and its next value is 0.
- Parity: par = ~^din (odd parity). Shift register b[8:0] = {par, din}, loaded on an accepted wr_ps2.
- Counters:
  - c_reg: RTS down-counter, width clog2(RTS_CYCLES).
  - n_reg: 4-bit bit counter.
- States:
  - idle
    - All oe = 0.
    - On wr_ps2: load b, set c = RTS_CYCLES-1, go to rts.
    - wr_ps2 in any other state is ignored; b is not modified.
  - rts
    - ps2c_oe=1, ps2d_oe=0. c decrements every cycle.
    - When c==0: go to start. Clock is held low for exactly RTS_CYCLES cycles.
    - fall_edge is ignored in this state; it is self-induced.
  - start
    - ps2c_oe=0, ps2d_oe=1 (start bit = 0).
    - On fall_edge: n=8, go to data.
  - data
    - ps2d_oe = ~b[0].
    - On fall_edge: b shifts right (b >> 1).
      - If n==0: go to stop.
      - Else: n = n-1.
    - Nine bits are sent: d0..d7, then parity.
  - stop
    - ps2d_oe=0 (stop bit = 1, line released).
    - On fall_edge: capture ack = ~ps2d, go to ack.
  - ack
    - All oe = 0.
    - Wait until the filtered clock = 1 and ps2d = 1 (bus released).
    - Then assert tx_done_tick for one cycle, set tx_err = ~ack, go to idle.
- tx_err is updated only in the tx_done_tick cycle. It holds until the next frame completes or reset.
- Outputs are combinational from the state and b.
- tx_idle=0 from the cycle after wr_ps2 is accepted through the tx_done_tick cycle.
- There is no watchdog. A silent device keeps the FSM in start, data or stop until rst=0.
- Simultaneous wr_ps2 and tx_done_tick: the FSM is not idle in that cycle, so wr_ps2 is ignored. The next wr_ps2 is accepted one cycle later.
- ps2c_oe and ps2d_oe are never both 1 except in the start state, where only ps2d_oe=1; so they are never simultaneously 1.

Test Plan:
- 0xF4, bench device model acks:
  - ps2c_oe=1 for exactly 5000 cycles, then ps2d_oe=1.
  - Device samples start=0, data 0,0,1,0,1,1,1,1, parity=0, stop=1.
  - tx_done_tick pulses once; tx_err=0; tx_idle returns to 1.
- 0x00:
  - Parity bit observed = 1.
  - 0xFF: parity observed = 1, ps2d_oe=0 on all data bits.
- No acknowledge: device holds ps2d high on the 11th falling edge -> tx_done_tick pulses and tx_err=1. A following good frame clears tx_err to 0.
- wr_ps2 with din=0x55 during the data phase of a 0xF4 frame -> ignored. The transmitted byte remains 0xF4 and exactly one tx_done_tick occurs.
- rst=0 for 1 cycle midway through data:
  - Next cycle: ps2c_oe=0, ps2d_oe=0, tx_idle=1, no tx_done_tick.
  - A new 0xFF frame then completes correctly.
- Glitch check: a ps2c low pulse shorter than 8 cycles during data -> no bit advance; the frame stays correct.
